prio_sel_arb: RTL

- Parametrised, registered successor to the team's four-way "last-select-wins" priority multiplexer.
- Selects one of N valid/ready request channels and presents its W-bit data on a registered output with valid/ready handshake.
- Two arbitration modes:
  - Mode 0: fixed priority, highest index wins. Same precedence as the combinational selector.
  - Mode 1: round-robin.
- When no channel requests, the output carries a programmable default value.
- Sits between multiple producers and a single consumer in datapath practice designs.

---
 rtl/prio_sel_arb.sv | 84 ++++++++
 1 files changed

// File: rtl/prio_sel_arb.sv
// Registered N-way request selector with fixed-priority (highest index wins)
// or round-robin arbitration, valid/ready on both sides, and a default word when idle.
module prio_sel_arb #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  input  logic [W-1:0]   dflt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic          any_req;
  logic          load;
  logic          found;
  logic [N-1:0]  win_onehot;
  logic [W-1:0]  win_data;
  int            idx;

  assign any_req = |req_valid;
  assign load    = !out_valid || out_ready;

  // Round-robin search begins just after the last winner and reaches 'last' itself at the end.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) winner = IW'(i);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last) + k) % N;
        if (!found && req_valid[idx]) begin
          winner = IW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = (int'(winner) == i);
    end
  end

  assign win_data  = req_data[int'(winner)*W +: W];
  assign req_ready = (load && any_req) ? win_onehot : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      last      <= IW'(N - 1);
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_grant <= win_onehot;
        if (mode) last <= winner;
      end else begin
        out_valid <= 1'b0;
        out_data  <= dflt;
        out_grant <= '0;
      end
    end
  end

endmodule
